// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALUControl codes, the FSM state
// encoding and a helper that tells legal codes from illegal ones.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'h0;
  localparam logic [3:0] CTRL_ADD = 4'h2;
  localparam logic [3:0] CTRL_SUB = 4'h6;
  localparam logic [3:0] CTRL_SLT = 4'h7;
  localparam logic [3:0] CTRL_NOR = 4'hC;
  localparam logic [3:0] CTRL_SLL = 4'hE;
  localparam logic [3:0] CTRL_NOP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic ctrl_is_legal(input logic [3:0] ctrl);
    logic legal;
    case (ctrl)
      CTRL_AND, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR, CTRL_SLL: legal = 1'b1;
      default:                                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: a lone request always wins; on contention the
// requester named by ptr wins. Grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between the main datapath (requester 0)
// and the branch/address unit (requester 1) with round-robin grant.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_rs0,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rt0,
  input  logic [31:0] req_rt1,
  input  logic [4:0]  req_shamt0,
  input  logic [4:0]  req_shamt1,
  input  logic [3:0]  req_ctrl0,
  input  logic [3:0]  req_ctrl1,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_rs_q, alu_rs_d;
  logic [31:0] alu_rt_q, alu_rt_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  gnt;
  logic        gnt_idx;
  logic [31:0] sel_rs;
  logic [31:0] sel_rt;
  logic [4:0]  sel_shamt;
  logic [3:0]  sel_ctrl;

  rr_arbiter2 u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign sel_rs    = gnt_idx ? req_rs1    : req_rs0;
  assign sel_rt    = gnt_idx ? req_rt1    : req_rt0;
  assign sel_shamt = gnt_idx ? req_shamt1 : req_shamt0;
  assign sel_ctrl  = gnt_idx ? req_ctrl1  : req_ctrl0;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    alu_rs_d      = alu_rs_q;
    alu_rt_d      = alu_rt_q;
    alu_shamt_d   = alu_shamt_q;
    alu_ctrl_d    = alu_ctrl_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
    req_ready     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          req_ready   = gnt;
          owner_d     = gnt_idx;
          alu_rs_d    = sel_rs;
          alu_rt_d    = sel_rt;
          alu_shamt_d = sel_shamt;
          if (ctrl_is_legal(sel_ctrl)) begin
            alu_ctrl_d = sel_ctrl;
            cnt_d      = LAT_INIT;
            state_d    = ST_EXEC;
          end else begin
            // Illegal codes never reach the ALU; answer immediately with an error.
            alu_ctrl_d    = CTRL_NOP;
            resp_err_d    = 1'b1;
            resp_result_d = 32'd0;
            resp_zero_d   = 1'b0;
            resp_valid_d  = gnt;
            state_d       = ST_RESP;
          end
        end
      end

      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          resp_result_d = alu_result;
          resp_zero_d   = alu_zero;
          resp_err_d    = 1'b0;
          resp_valid_d  = owner_q ? 2'b10 : 2'b01;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // Pointer flips only on a completed response, so a waiting requester goes next.
        if (resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          alu_ctrl_d   = CTRL_NOP;
          rr_ptr_d     = ~owner_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      cnt_q         <= 4'd0;
      alu_rs_q      <= 32'd0;
      alu_rt_q      <= 32'd0;
      alu_shamt_q   <= 5'd0;
      alu_ctrl_q    <= CTRL_NOP;
      resp_valid_q  <= 2'b00;
      resp_result_q <= 32'd0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      alu_rs_q      <= alu_rs_d;
      alu_rt_q      <= alu_rt_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign alu_rs      = alu_rs_q;
  assign alu_rt      = alu_rt_q;
  assign alu_shamt   = alu_shamt_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: two instances (ALU_LAT=1 and 3), each with
// a behavioural ALU stub, directed scenarios and randomized traffic vs a queue-free model.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam logic [3:0] NOP = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid [N];
  logic [1:0]  req_ready [N];
  logic [31:0] req_rs0 [N];
  logic [31:0] req_rs1 [N];
  logic [31:0] req_rt0 [N];
  logic [31:0] req_rt1 [N];
  logic [4:0]  req_shamt0 [N];
  logic [4:0]  req_shamt1 [N];
  logic [3:0]  req_ctrl0 [N];
  logic [3:0]  req_ctrl1 [N];
  logic [1:0]  resp_valid [N];
  logic [1:0]  resp_ready [N];
  logic [31:0] resp_result [N];
  logic        resp_zero [N];
  logic        resp_err [N];
  logic [31:0] alu_rs [N];
  logic [31:0] alu_rt [N];
  logic [4:0]  alu_shamt [N];
  logic [3:0]  alu_ctrl [N];
  logic [31:0] alu_result [N];
  logic        alu_zero [N];

  // Model state: pending requests per instance/requester and the round-robin priority.
  logic        p_v [N][2];
  logic [31:0] p_rs [N][2];
  logic [31:0] p_rt [N][2];
  logic [4:0]  p_sh [N][2];
  logic [3:0]  p_ctrl [N][2];
  int          prio [N];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (c)
      4'h0:    return a & b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      4'hE:    return b << sh;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    alu_arbiter #(.ALU_LAT(gi == 0 ? 1 : 3)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid[gi]),
      .req_ready   (req_ready[gi]),
      .req_rs0     (req_rs0[gi]),
      .req_rs1     (req_rs1[gi]),
      .req_rt0     (req_rt0[gi]),
      .req_rt1     (req_rt1[gi]),
      .req_shamt0  (req_shamt0[gi]),
      .req_shamt1  (req_shamt1[gi]),
      .req_ctrl0   (req_ctrl0[gi]),
      .req_ctrl1   (req_ctrl1[gi]),
      .resp_valid  (resp_valid[gi]),
      .resp_ready  (resp_ready[gi]),
      .resp_result (resp_result[gi]),
      .resp_zero   (resp_zero[gi]),
      .resp_err    (resp_err[gi]),
      .alu_rs      (alu_rs[gi]),
      .alu_rt      (alu_rt[gi]),
      .alu_shamt   (alu_shamt[gi]),
      .alu_ctrl    (alu_ctrl[gi]),
      .alu_result  (alu_result[gi]),
      .alu_zero    (alu_zero[gi])
    );
    assign alu_result[gi] = ref_alu(alu_ctrl[gi], alu_rs[gi], alu_rt[gi], alu_shamt[gi]);
    assign alu_zero[gi]   = (alu_result[gi] == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input int k);
    req_valid[k]  = {p_v[k][1], p_v[k][0]};
    req_rs0[k]    = p_rs[k][0];
    req_rs1[k]    = p_rs[k][1];
    req_rt0[k]    = p_rt[k][0];
    req_rt1[k]    = p_rt[k][1];
    req_shamt0[k] = p_sh[k][0];
    req_shamt1[k] = p_sh[k][1];
    req_ctrl0[k]  = p_ctrl[k][0];
    req_ctrl1[k]  = p_ctrl[k][1];
  endtask

  task automatic set_req(input int k, input int r, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    p_v[k][r]    = 1'b1;
    p_ctrl[k][r] = c;
    p_rs[k][r]   = a;
    p_rt[k][r]   = b;
    p_sh[k][r]   = sh;
  endtask

  task automatic check_reset_state(input int k);
    check("rst_resp_valid", resp_valid[k], 2'b00);
    check("rst_req_ready", req_ready[k], 2'b00);
    check("rst_alu_ctrl", alu_ctrl[k], NOP);
    check("rst_alu_rs", alu_rs[k], 32'd0);
    check("rst_alu_rt", alu_rt[k], 32'd0);
    check("rst_alu_shamt", alu_shamt[k], 5'd0);
    check("rst_result", resp_result[k], 32'd0);
    check("rst_zero", resp_zero[k], 1'b0);
    check("rst_err", resp_err[k], 1'b0);
  endtask

  // Asserts reset at the current (mid-cycle) time and releases it on a later negedge.
  task automatic apply_reset();
    for (int k = 0; k < N; k++) begin
      p_v[k][0] = 1'b0;
      p_v[k][1] = 1'b0;
      prio[k]   = 0;
      drive(k);
      resp_ready[k] = 2'b00;
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) check_reset_state(k);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one grant-to-handshake transaction from the pending set; starts and ends mid-low-phase.
  task automatic run_op(input int k, input int hold);
    int          w;
    logic [1:0]  oh;
    logic        legal;
    logic [3:0]  c;
    logic [31:0] a, b, er;
    logic [4:0]  sh;
    logic        ez;
    int          exp_cyc;
    if (p_v[k][0] && p_v[k][1]) w = prio[k];
    else w = p_v[k][0] ? 0 : 1;
    oh = (w == 0) ? 2'b01 : 2'b10;
    c  = p_ctrl[k][w];
    a  = p_rs[k][w];
    b  = p_rt[k][w];
    sh = p_sh[k][w];
    legal   = c inside {4'h0, 4'h2, 4'h6, 4'h7, 4'hC, 4'hE};
    er      = legal ? ref_alu(c, a, b, sh) : 32'd0;
    ez      = legal ? (er == 32'd0) : 1'b0;
    exp_cyc = legal ? lat_of(k) + 1 : 1;

    drive(k);
    #1;
    check("grant", req_ready[k], oh);
    @(posedge clk);
    p_v[k][w] = 1'b0;
    for (int i = 1; i <= exp_cyc; i++) begin
      @(negedge clk);
      drive(k);
      #1;
      check("ready_busy", req_ready[k], 2'b00);
      check("alu_rs", alu_rs[k], a);
      check("alu_rt", alu_rt[k], b);
      check("alu_shamt", alu_shamt[k], sh);
      check("alu_ctrl", alu_ctrl[k], legal ? c : NOP);
      if (i < exp_cyc) check("resp_early", resp_valid[k], 2'b00);
    end
    check("resp_valid", resp_valid[k], oh);
    check("resp_result", resp_result[k], er);
    check("resp_zero", resp_zero[k], ez);
    check("resp_err", resp_err[k], !legal);

    resp_ready[k] = ~oh;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", resp_valid[k], oh);
      check("hold_result", resp_result[k], er);
      check("hold_err", resp_err[k], !legal);
      check("hold_ready", req_ready[k], 2'b00);
    end
    resp_ready[k] = oh;
    @(posedge clk);
    @(negedge clk);
    resp_ready[k] = 2'b00;
    prio[k] = 1 - w;
    #1;
    check("resp_done", resp_valid[k], 2'b00);
    check("ctrl_nop", alu_ctrl[k], NOP);
    $display("op inst=%0d req=%0d ctrl=%h rs=%h rt=%h sh=%0d -> result=%h zero=%0d err=%0d hold=%0d",
             k, w, c, a, b, sh, er, ez, !legal, hold);
  endtask

  function automatic logic [3:0] rand_ctrl();
    logic [3:0] c;
    case ($urandom_range(0, 6))
      0: c = 4'h0;
      1: c = 4'h2;
      2: c = 4'h6;
      3: c = 4'h7;
      4: c = 4'hC;
      5: c = 4'hE;
      default: begin
        c = 4'($urandom_range(0, 15));
        while (c inside {4'h0, 4'h2, 4'h6, 4'h7, 4'hC, 4'hE}) c = 4'($urandom_range(0, 15));
      end
    endcase
    return c;
  endfunction

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 2; r++) begin
        p_v[k][r] = 1'b0; p_rs[k][r] = '0; p_rt[k][r] = '0; p_sh[k][r] = '0; p_ctrl[k][r] = '0;
      end
      prio[k] = 0;
      resp_ready[k] = 2'b00;
      drive(k);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) check_reset_state(k);
    @(negedge clk);
    reset = 1'b0;

    // Requester 0 alone, ADD 5+7.
    set_req(0, 0, 4'h2, 32'd5, 32'd7, 5'd0);
    run_op(0, 0);

    // Contention straight after reset: r0 wins, then r1; r0 response backpressured 5 cycles.
    apply_reset();
    set_req(0, 0, 4'h6, 32'd9, 32'd9, 5'd0);
    set_req(0, 1, 4'h2, 32'd1, 32'd1, 5'd0);
    run_op(0, 5);
    run_op(0, 0);

    // Illegal code from r1.
    set_req(0, 1, 4'h5, 32'h1234, 32'h5678, 5'd3);
    run_op(0, 1);

    // ALU_LAT=3: SLL 1<<4, issued by r0 so the pointer moves to r1.
    set_req(1, 0, 4'hE, 32'd0, 32'd1, 5'd4);
    run_op(1, 0);

    // Reset during EXEC discards the op and returns the pointer to r0.
    set_req(1, 0, 4'h2, 32'd3, 32'd4, 5'd0);
    drive(1);
    @(posedge clk);
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("no_resp_after_rst", resp_valid[1], 2'b00);
    end
    set_req(1, 0, 4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    set_req(1, 1, 4'hC, 32'h0000_FFFF, 32'h00FF_0000, 5'd0);
    run_op(1, 0);
    run_op(1, 0);
    set_req(1, 1, 4'h7, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op(1, 0);

    // Randomized traffic on both instances.
    for (int k = 0; k < N; k++) begin
      for (int it = 0; it < 40; it++) begin
        for (int r = 0; r < 2; r++) begin
          if (!p_v[k][r] && $urandom_range(0, 1) == 1) begin
            a = $urandom;
            set_req(k, r, rand_ctrl(), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                    5'($urandom_range(0, 31)));
          end
        end
        if (!p_v[k][0] && !p_v[k][1]) begin
          a = $urandom;
          set_req(k, $urandom_range(0, 1), rand_ctrl(), a, $urandom, 5'($urandom_range(0, 31)));
        end
        run_op(k, $urandom_range(0, 3));
      end
      while (p_v[k][0] || p_v[k][1]) run_op(k, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
